bc_turn_controller: RTL and testbench
=====================================

Name: bc_turn_controller

Overview:
- Game sequencer for the Nexys-A7 Bulls & Cows design.
- Accepts the secret entry for player 1 and then player 2 from the switches. Digits must be distinct decimal digits.
- Alternates guesses P1, P2 within each round and hands each guess to the external scoring datapath through a start/done handshake.
- Holds each result for display, then declares a winner or draw. Display and LED drivers consume its outputs.

Parameters:
- RESULT_HOLD, 100_000_000: cycles each score is held in SHOW (1 s at 100 MHz). Must be at least 1.
- MAX_TURNS, 10: rounds before a forced draw. Range 1..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- confirma  in  1  single-cycle confirm pulse, already debounced.
- sw_value  in  16  four nibbles [15:12],[11:8],[7:4],[3:0], each one digit.
- reject  out  1  one-cycle pulse: confirma arrived with an invalid entry.
- score_start  out  1  one-cycle pulse to the scorer.
- score_secret  out  16  secret to score against.
- score_guess  out  16  latched guess.
- score_done  in  1  scorer result valid.
- score_bulls  in  3  bulls count, 0..4.
- score_cows  in  3  cows count, 0..4.
- phase  out  3  0=SECRET1, 1=SECRET2, 2=GUESS, 3=SCORE, 4=SHOW, 5=OVER.
- player  out  1  current guesser: 0=P1 (scored vs P2 secret), 1=P2 (scored vs P1 secret).
- turn_count  out  4  current round, 1-based.
- last_bulls  out  3  latched result.
- last_cows  out  3  latched result.
- winner  out  2  00=none, 01=P1, 10=P2, 11=draw.
- game_over  out  1  high in OVER.

Behaviour:
- Reset (reset==0 at a clock edge) clears every register:
  - phase=0; all other outputs 0.
  - Internal secrets, guess, hit flags and hold timer are also 0.
  - Reset applies from any state, including mid-SCORE; a late score_done after reset is ignored.
- Valid entry, evaluated combinationally on sw_value in the same cycle as confirma:
  - every nibble is ≤9;
  - all four nibbles are pairwise distinct.
  - Example: 0x1234 is valid; 0x1123 and 0x12A4 are invalid.
- confirma with an invalid entry in SECRET1, SECRET2 or GUESS: reject=1 for the next cycle, state unchanged.
- confirma in SCORE, SHOW or OVER: ignored, no reject.
- SECRET1: valid confirma latches p1_secret, go to SECRET2.
- SECRET2: valid confirma latches p2_secret, go to GUESS with player=0, turn_count=1.
- GUESS: valid confirma latches score_guess and drives score_secret:
  - player=0 → p2_secret; player=1 → p1_secret.
  - score_start=1 for exactly the next cycle; phase=SCORE from that same cycle.
  - score_secret and score_guess stay stable until leaving SCORE.
- SCORE: waits indefinitely for score_done, accepted in any SCORE cycle including the score_start cycle.
  - On done: latch last_bulls and last_cows.
  - If score_bulls==4, set hit flag of the current player.
  - Load hold timer with RESULT_HOLD-1, go to SHOW.
  - score_done outside SCORE is ignored.
- SHOW: timer decrements each cycle. On the cycle the timer reads 0, apply the first matching rule:
  - player=0 → player=1, go to GUESS. P2 always gets the equalising turn, even if P1 hit.
  - player=1, both hit → winner=11, OVER.
  - player=1, P1 hit only → winner=01, OVER.
  - player=1, P2 hit only → winner=10, OVER.
  - player=1, no hit, turn_count==MAX_TURNS → winner=11, OVER.
  - otherwise → turn_count+1, player=0, GUESS.
- OVER: game_over=1. winner, last_bulls, last_cows and turn_count hold. Only reset leaves OVER.
- last_bulls and last_cows persist across GUESS until the next score_done.
- All outputs are registered except score_secret, which is a mux of registers selected by player.

Test Plan:
- Reset mid-SCORE: reset=0 for one edge while in SCORE, then a late score_done → phase=0, all outputs 0, and the late done is ignored.
- Secret validation: confirma with sw_value=0x1123, then 0x12A4 → reject pulses twice, phase stays 0. Then 0x1234 → phase=1. Then 0x5678 → phase=2, player=0, turn_count=1.
- Handshake: guess 0x5670 → score_start high for one cycle with score_secret=0x5678, score_guess=0x5670. Scorer returns done after 3 cycles with bulls=3, cows=0 → last_bulls=3, phase=4 for RESULT_HOLD cycles (bench uses RESULT_HOLD=4). confirma during SHOW is ignored.
- Equalising turn / draw: P1 guesses 0x5678 (bulls=4) → P2 gets a turn. P2 guesses 0x1234 (bulls=4) → winner=11, game_over=1. Further confirma has no effect.
- P2 win: round 1 has no hits. In round 2 P2 alone scores bulls=4 → winner=10 at turn_count=2.
- Turn limit with MAX_TURNS=2: no hits in either round → after P2's SHOW in round 2, winner=11 and turn_count stays 2.

Source files
------------

// File: rtl/bc_turn_controller_if.sv
// Scorer link for the Bulls & Cows turn controller: request (secret/guess) out, result (bulls/cows) back.
//
// Handshake: score_start pulses for one cycle when score_secret/score_guess become valid.
// Both stay stable until the scorer raises score_done, which qualifies score_bulls/score_cows.
// The controller ignores score_done while no request is outstanding.
interface bc_turn_controller_if;
    logic        score_start;
    logic [15:0] score_secret;
    logic [15:0] score_guess;
    logic        score_done;
    logic [2:0]  score_bulls;
    logic [2:0]  score_cows;

    modport master (
        output score_start, score_secret, score_guess,
        input  score_done, score_bulls, score_cows
    );

    modport slave (
        input  score_start, score_secret, score_guess,
        output score_done, score_bulls, score_cows
    );
endinterface

// File: rtl/bc_turn_controller.sv
// Bulls & Cows game sequencer: secret entry for both players, alternating guesses,
// scorer handshake, result hold and winner/draw decision.
module bc_turn_controller #(
    parameter int unsigned RESULT_HOLD = 100_000_000,
    parameter int unsigned MAX_TURNS   = 10
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         confirma,
    input  logic [15:0]                  sw_value,
    output logic                         reject,
    bc_turn_controller_if.master         score,
    output logic [2:0]                   phase,
    output logic                         player,
    output logic [3:0]                   turn_count,
    output logic [2:0]                   last_bulls,
    output logic [2:0]                   last_cows,
    output logic [1:0]                   winner,
    output logic                         game_over
);

    typedef enum logic [2:0] {
        SECRET1 = 3'd0,
        SECRET2 = 3'd1,
        GUESS   = 3'd2,
        SCORE   = 3'd3,
        SHOW    = 3'd4,
        OVER    = 3'd5
    } state_t;

    localparam logic [31:0] HOLD_LOAD  = 32'(RESULT_HOLD - 1);
    localparam logic [3:0]  TURN_LIMIT = 4'(MAX_TURNS);

    state_t      state, state_n;
    logic [15:0] p1_secret, p1_secret_n;
    logic [15:0] p2_secret, p2_secret_n;
    logic [15:0] guess, guess_n;
    logic        player_n;
    logic [3:0]  turn_n;
    logic [2:0]  bulls_n, cows_n;
    logic [1:0]  winner_n;
    logic        p1_hit, p1_hit_n;
    logic        p2_hit, p2_hit_n;
    logic [31:0] hold, hold_n;
    logic        reject_n;
    logic        start_q, start_n;
    logic        over_n;
    logic        entry_valid;

    // Entry is valid when every nibble is a decimal digit and no digit repeats.
    always_comb begin
        entry_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (sw_value[4*i +: 4] > 4'd9) entry_valid = 1'b0;
            for (int j = i + 1; j < 4; j++) begin
                if (sw_value[4*i +: 4] == sw_value[4*j +: 4]) entry_valid = 1'b0;
            end
        end
    end

    always_comb begin
        state_n     = state;
        p1_secret_n = p1_secret;
        p2_secret_n = p2_secret;
        guess_n     = guess;
        player_n    = player;
        turn_n      = turn_count;
        bulls_n     = last_bulls;
        cows_n      = last_cows;
        winner_n    = winner;
        p1_hit_n    = p1_hit;
        p2_hit_n    = p2_hit;
        hold_n      = hold;
        reject_n    = 1'b0;
        start_n     = 1'b0;

        case (state)
            SECRET1: if (confirma) begin
                if (entry_valid) begin
                    p1_secret_n = sw_value;
                    state_n     = SECRET2;
                end else begin
                    reject_n = 1'b1;
                end
            end
            SECRET2: if (confirma) begin
                if (entry_valid) begin
                    p2_secret_n = sw_value;
                    player_n    = 1'b0;
                    turn_n      = 4'd1;
                    state_n     = GUESS;
                end else begin
                    reject_n = 1'b1;
                end
            end
            GUESS: if (confirma) begin
                if (entry_valid) begin
                    guess_n = sw_value;
                    start_n = 1'b1;
                    state_n = SCORE;
                end else begin
                    reject_n = 1'b1;
                end
            end
            SCORE: if (score.score_done) begin
                bulls_n = score.score_bulls;
                cows_n  = score.score_cows;
                if (score.score_bulls == 3'd4) begin
                    if (player) p2_hit_n = 1'b1;
                    else        p1_hit_n = 1'b1;
                end
                hold_n  = HOLD_LOAD;
                state_n = SHOW;
            end
            SHOW: begin
                if (hold != 32'd0) begin
                    hold_n = hold - 32'd1;
                end else if (!player) begin
                    // P2 always gets the equalising turn, even after a P1 hit.
                    player_n = 1'b1;
                    state_n  = GUESS;
                end else if (p1_hit && p2_hit) begin
                    winner_n = 2'b11;
                    state_n  = OVER;
                end else if (p1_hit) begin
                    winner_n = 2'b01;
                    state_n  = OVER;
                end else if (p2_hit) begin
                    winner_n = 2'b10;
                    state_n  = OVER;
                end else if (turn_count == TURN_LIMIT) begin
                    winner_n = 2'b11;
                    state_n  = OVER;
                end else begin
                    turn_n   = turn_count + 4'd1;
                    player_n = 1'b0;
                    state_n  = GUESS;
                end
            end
            OVER: ;
            default: state_n = SECRET1;
        endcase

        over_n = (state_n == OVER);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= SECRET1;
            p1_secret  <= '0;
            p2_secret  <= '0;
            guess      <= '0;
            player     <= 1'b0;
            turn_count <= '0;
            last_bulls <= '0;
            last_cows  <= '0;
            winner     <= '0;
            p1_hit     <= 1'b0;
            p2_hit     <= 1'b0;
            hold       <= '0;
            reject     <= 1'b0;
            start_q    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_n;
            p1_secret  <= p1_secret_n;
            p2_secret  <= p2_secret_n;
            guess      <= guess_n;
            player     <= player_n;
            turn_count <= turn_n;
            last_bulls <= bulls_n;
            last_cows  <= cows_n;
            winner     <= winner_n;
            p1_hit     <= p1_hit_n;
            p2_hit     <= p2_hit_n;
            hold       <= hold_n;
            reject     <= reject_n;
            start_q    <= start_n;
            game_over  <= over_n;
        end
    end

    // P1 guesses against P2's secret and vice versa.
    assign score.score_secret = player ? p1_secret : p2_secret;
    assign score.score_guess  = guess;
    assign score.score_start  = start_q;
    assign phase              = state;

endmodule

// File: tb/tb_bc_turn_controller.sv
// Self-checking bench for bc_turn_controller: scripted game scenarios plus randomized
// games scored by a bench-side Bulls & Cows model.
module tb_bc_turn_controller;

    localparam int RESULT_HOLD = 4;
    localparam int MAX_TURNS   = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        confirma = 1'b0;
    logic [15:0] sw_value = '0;
    logic        reject;
    logic [2:0]  phase;
    logic        player;
    logic [3:0]  turn_count;
    logic [2:0]  last_bulls, last_cows;
    logic [1:0]  winner;
    logic        game_over;

    int checks = 0;
    int passes = 0;

    bc_turn_controller_if sif ();

    bc_turn_controller #(
        .RESULT_HOLD (RESULT_HOLD),
        .MAX_TURNS   (MAX_TURNS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .confirma   (confirma),
        .sw_value   (sw_value),
        .reject     (reject),
        .score      (sif),
        .phase      (phase),
        .player     (player),
        .turn_count (turn_count),
        .last_bulls (last_bulls),
        .last_cows  (last_cows),
        .winner     (winner),
        .game_over  (game_over)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic void score_ref(input logic [15:0] s, input logic [15:0] g,
                                      output logic [2:0] b, output logic [2:0] c);
        b = 3'd0;
        c = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[4*i +: 4] == s[4*i +: 4]) b = b + 3'd1;
            else for (int j = 0; j < 4; j++)
                if (j != i && g[4*i +: 4] == s[4*j +: 4]) c = c + 3'd1;
        end
    endfunction

    function automatic logic [15:0] rand_code();
        logic [3:0] d [10];
        logic [3:0] t;
        int j;
        for (int i = 0; i < 10; i++) d[i] = 4'(i);
        for (int i = 9; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = d[i]; d[i] = d[j]; d[j] = t;
        end
        return {d[3], d[2], d[1], d[0]};
    endfunction

    function automatic logic [15:0] rand_miss(input logic [15:0] secret);
        logic [15:0] r;
        do r = rand_code(); while (r == secret);
        return r;
    endfunction

    function automatic logic [15:0] rand_bad();
        logic [15:0] r;
        int k;
        r = rand_code();
        k = $urandom_range(3, 0);
        if ($urandom_range(1, 0) == 1) r[4*k +: 4] = 4'($urandom_range(15, 10));
        else                           r[4*k +: 4] = r[4*((k + 1) % 4) +: 4];
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic confirm(input logic [15:0] v);
        sw_value = v;
        confirma = 1'b1;
        tick();
        confirma = 1'b0;
    endtask

    task automatic setup_game(input logic [15:0] p1, input logic [15:0] p2);
        apply_reset();
        confirm(p1);
        confirm(p2);
    endtask

    // Enters a guess, plays the scorer with model results, and returns what was observed.
    task automatic do_turn(input logic [15:0] g, input logic [15:0] model_secret, input int delay,
                           output logic start_seen, output logic [15:0] sec_seen,
                           output logic [15:0] guess_seen, output int start_cnt, output int show_len);
        logic [2:0] b, c;
        score_ref(model_secret, g, b, c);
        confirm(g);
        start_seen = sif.score_start;
        sec_seen   = sif.score_secret;
        guess_seen = sif.score_guess;
        start_cnt  = sif.score_start ? 1 : 0;
        for (int i = 0; i < delay; i++) begin
            tick();
            if (sif.score_start) start_cnt++;
        end
        sif.score_done  = 1'b1;
        sif.score_bulls = b;
        sif.score_cows  = c;
        tick();
        sif.score_done = 1'b0;
        show_len = 0;
        while (phase == 3'd4 && show_len < 50) begin
            show_len++;
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        checks++; if ({phase, player, turn_count, last_bulls, last_cows, winner, game_over, reject, sif.score_start} !== '0)
            $display("FAIL reset_outputs: got %0h expected 0", {phase, player, turn_count, last_bulls, last_cows, winner, game_over, reject, sif.score_start});
        else passes++;
        checks++; if ({sif.score_secret, sif.score_guess} !== 32'h0)
            $display("FAIL reset_bus: got %h expected 0", {sif.score_secret, sif.score_guess});
        else passes++;
    endtask

    task automatic test_reset_mid_score();
        setup_game(16'h1234, 16'h5678);
        confirm(16'h5670);
        checks++; if (phase !== 3'd3 || sif.score_start !== 1'b1)
            $display("FAIL mid_enter_score: got phase %0d start %0b expected 3 1", phase, sif.score_start);
        else passes++;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++; if ({phase, player, turn_count, last_bulls, last_cows, winner, game_over, reject, sif.score_start, sif.score_secret, sif.score_guess} !== '0)
            $display("FAIL mid_reset_clear: got %0h expected 0", {phase, player, turn_count, last_bulls, last_cows, winner, game_over, reject, sif.score_start, sif.score_secret, sif.score_guess});
        else passes++;
        sif.score_done = 1'b1; sif.score_bulls = 3'd4; sif.score_cows = 3'd0;
        tick();
        sif.score_done = 1'b0;
        tick();
        checks++; if (phase !== 3'd0 || last_bulls !== 3'd0 || winner !== 2'd0)
            $display("FAIL mid_late_done: got phase %0d bulls %0d winner %0d expected 0 0 0", phase, last_bulls, winner);
        else passes++;
    endtask

    task automatic test_secret_validation();
        apply_reset();
        confirm(16'h1123);
        checks++; if (reject !== 1'b1 || phase !== 3'd0)
            $display("FAIL val_dup: got reject %0b phase %0d expected 1 0", reject, phase);
        else passes++;
        tick();
        checks++; if (reject !== 1'b0)
            $display("FAIL val_reject_width: got %0b expected 0", reject);
        else passes++;
        confirm(16'h12A4);
        checks++; if (reject !== 1'b1 || phase !== 3'd0)
            $display("FAIL val_hex: got reject %0b phase %0d expected 1 0", reject, phase);
        else passes++;
        confirm(16'h1234);
        checks++; if (reject !== 1'b0 || phase !== 3'd1)
            $display("FAIL val_secret1: got reject %0b phase %0d expected 0 1", reject, phase);
        else passes++;
        confirm(16'h5678);
        checks++; if (phase !== 3'd2 || player !== 1'b0 || turn_count !== 4'd1)
            $display("FAIL val_secret2: got phase %0d player %0b turn %0d expected 2 0 1", phase, player, turn_count);
        else passes++;
    endtask

    task automatic test_handshake();
        logic s; logic [15:0] sec, gs; int sc, sl, n;
        confirm(16'h5670);
        checks++; if (sif.score_start !== 1'b1 || phase !== 3'd3 || sif.score_secret !== 16'h5678 || sif.score_guess !== 16'h5670)
            $display("FAIL hs_start: got start %0b phase %0d secret %h guess %h expected 1 3 5678 5670", sif.score_start, phase, sif.score_secret, sif.score_guess);
        else passes++;
        tick();
        checks++; if (sif.score_start !== 1'b0 || phase !== 3'd3 || sif.score_secret !== 16'h5678)
            $display("FAIL hs_wait: got start %0b phase %0d secret %h expected 0 3 5678", sif.score_start, phase, sif.score_secret);
        else passes++;
        tick();
        tick();
        sif.score_done = 1'b1; sif.score_bulls = 3'd3; sif.score_cows = 3'd0;
        tick();
        sif.score_done = 1'b0;
        checks++; if (phase !== 3'd4 || last_bulls !== 3'd3 || last_cows !== 3'd0)
            $display("FAIL hs_result: got phase %0d bulls %0d cows %0d expected 4 3 0", phase, last_bulls, last_cows);
        else passes++;
        confirm(16'h9876);
        checks++; if (phase !== 3'd4 || reject !== 1'b0 || sif.score_start !== 1'b0)
            $display("FAIL hs_show_confirm: got phase %0d reject %0b start %0b expected 4 0 0", phase, reject, sif.score_start);
        else passes++;
        n = 2;
        for (int k = 0; k < 50 && phase == 3'd4; k++) begin
            tick();
            if (phase == 3'd4) n++;
        end
        checks++; if (n !== RESULT_HOLD || phase !== 3'd2 || player !== 1'b1)
            $display("FAIL hs_show_len: got len %0d phase %0d player %0b expected %0d 2 1", n, phase, player, RESULT_HOLD);
        else passes++;
        do_turn(16'h1243, 16'h1234, $urandom_range(4, 0), s, sec, gs, sc, sl);
        checks++; if (sec !== 16'h1234 || last_bulls !== 3'd2 || last_cows !== 3'd2)
            $display("FAIL hs_p2_turn: got secret %h bulls %0d cows %0d expected 1234 2 2", sec, last_bulls, last_cows);
        else passes++;
        checks++; if (phase !== 3'd2 || player !== 1'b0 || turn_count !== 4'd2)
            $display("FAIL hs_round2: got phase %0d player %0b turn %0d expected 2 0 2", phase, player, turn_count);
        else passes++;
    endtask

    task automatic test_equalising_draw();
        logic s; logic [15:0] sec, gs; int sc, sl;
        do_turn(16'h5678, 16'h5678, 1, s, sec, gs, sc, sl);
        checks++; if (last_bulls !== 3'd4 || phase !== 3'd2 || player !== 1'b1 || winner !== 2'd0)
            $display("FAIL eq_turn: got bulls %0d phase %0d player %0b winner %0d expected 4 2 1 0", last_bulls, phase, player, winner);
        else passes++;
        do_turn(16'h1234, 16'h1234, 0, s, sec, gs, sc, sl);
        checks++; if (winner !== 2'b11 || game_over !== 1'b1 || phase !== 3'd5 || turn_count !== 4'd2)
            $display("FAIL eq_draw: got winner %0d over %0b phase %0d turn %0d expected 3 1 5 2", winner, game_over, phase, turn_count);
        else passes++;
        confirm(16'h4321);
        confirm(16'h1123);
        tick();
        checks++; if (phase !== 3'd5 || reject !== 1'b0 || sif.score_start !== 1'b0 || winner !== 2'b11 || last_bulls !== 3'd4)
            $display("FAIL eq_over_hold: got phase %0d reject %0b start %0b winner %0d bulls %0d expected 5 0 0 3 4", phase, reject, sif.score_start, winner, last_bulls);
        else passes++;
    endtask

    task automatic test_p2_win();
        logic s; logic [15:0] sec, gs, p1, p2; int sc, sl;
        p1 = rand_code();
        p2 = rand_code();
        setup_game(p1, p2);
        do_turn(rand_miss(p2), p2, $urandom_range(3, 0), s, sec, gs, sc, sl);
        do_turn(rand_miss(p1), p1, $urandom_range(3, 0), s, sec, gs, sc, sl);
        do_turn(rand_miss(p2), p2, $urandom_range(3, 0), s, sec, gs, sc, sl);
        checks++; if (winner !== 2'd0 || phase !== 3'd2 || player !== 1'b1)
            $display("FAIL p2_before: got winner %0d phase %0d player %0b expected 0 2 1", winner, phase, player);
        else passes++;
        do_turn(p1, p1, $urandom_range(3, 0), s, sec, gs, sc, sl);
        checks++; if (winner !== 2'b10 || turn_count !== 4'd2 || game_over !== 1'b1 || phase !== 3'd5)
            $display("FAIL p2_win: got winner %0d turn %0d over %0b phase %0d expected 2 2 1 5", winner, turn_count, game_over, phase);
        else passes++;
    endtask

    task automatic test_turn_limit();
        logic s; logic [15:0] sec, gs, p1, p2; int sc, sl;
        p1 = rand_code();
        p2 = rand_code();
        setup_game(p1, p2);
        do_turn(rand_miss(p2), p2, 1, s, sec, gs, sc, sl);
        do_turn(rand_miss(p1), p1, 2, s, sec, gs, sc, sl);
        checks++; if (turn_count !== 4'd2 || phase !== 3'd2 || player !== 1'b0)
            $display("FAIL limit_round2: got turn %0d phase %0d player %0b expected 2 2 0", turn_count, phase, player);
        else passes++;
        do_turn(rand_miss(p2), p2, 0, s, sec, gs, sc, sl);
        do_turn(rand_miss(p1), p1, 3, s, sec, gs, sc, sl);
        checks++; if (winner !== 2'b11 || turn_count !== 4'd2 || game_over !== 1'b1)
            $display("FAIL limit_draw: got winner %0d turn %0d over %0b expected 3 2 1", winner, turn_count, game_over);
        else passes++;
    endtask

    task automatic test_random_games();
        logic s; logic [15:0] sec, gs, p1, p2, tgt, g; int sc, sl;
        logic [2:0] eb, ec;
        logic m_p1h, m_p2h, m_player, m_over;
        logic [1:0] m_winner;
        int m_round;
        for (int game = 0; game < 12; game++) begin
            p1 = rand_code();
            p2 = rand_code();
            setup_game(p1, p2);
            m_p1h = 0; m_p2h = 0; m_player = 0; m_over = 0; m_winner = 2'd0; m_round = 1;
            while (!m_over) begin
                tgt = m_player ? p1 : p2;
                if ($urandom_range(2, 0) == 0) begin
                    confirm(rand_bad());
                    checks++; if (reject !== 1'b1 || phase !== 3'd2)
                        $display("FAIL rnd_reject: got reject %0b phase %0d expected 1 2", reject, phase);
                    else passes++;
                end
                g = ($urandom_range(3, 0) == 0) ? tgt : rand_miss(tgt);
                score_ref(tgt, g, eb, ec);
                do_turn(g, tgt, $urandom_range(4, 0), s, sec, gs, sc, sl);
                checks++; if (s !== 1'b1 || sc !== 1 || sec !== tgt || gs !== g)
                    $display("FAIL rnd_request: got start %0b cnt %0d secret %h guess %h expected 1 1 %h %h", s, sc, sec, gs, tgt, g);
                else passes++;
                checks++; if (last_bulls !== eb || last_cows !== ec || sl !== RESULT_HOLD)
                    $display("FAIL rnd_result: got bulls %0d cows %0d show %0d expected %0d %0d %0d", last_bulls, last_cows, sl, eb, ec, RESULT_HOLD);
                else passes++;
                if (eb == 3'd4) begin
                    if (m_player) m_p2h = 1; else m_p1h = 1;
                end
                if (!m_player) begin
                    m_player = 1;
                end else begin
                    if (m_p1h && m_p2h)         m_winner = 2'b11;
                    else if (m_p1h)             m_winner = 2'b01;
                    else if (m_p2h)             m_winner = 2'b10;
                    else if (m_round == MAX_TURNS) m_winner = 2'b11;
                    if (m_winner != 2'd0) m_over = 1;
                    else begin
                        m_round++;
                        m_player = 0;
                    end
                end
                checks++; if (winner !== m_winner || game_over !== m_over || phase !== (m_over ? 3'd5 : 3'd2)
                              || turn_count !== 4'(m_round) || (!m_over && player !== m_player))
                    $display("FAIL rnd_progress: got winner %0d over %0b phase %0d turn %0d player %0b expected %0d %0b %0d %0d %0b",
                             winner, game_over, phase, turn_count, player, m_winner, m_over, m_over ? 5 : 2, m_round, m_player);
                else passes++;
            end
        end
    endtask

    initial begin
        sif.score_done  = 1'b0;
        sif.score_bulls = 3'd0;
        sif.score_cows  = 3'd0;
        test_reset();
        test_reset_mid_score();
        test_secret_validation();
        test_handshake();
        test_equalising_draw();
        test_p2_win();
        test_turn_limit();
        test_random_games();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
